multicycle_control_unit: RTL



---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/multicycle_control_unit_if.sv | 10 +
 rtl/ctrl_wait_timer.sv | 24 ++
 rtl/multicycle_control_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode encodings,
// FSM state encoding and default parameter values.
package ctrl_pkg;

  localparam int unsigned OPCODE_W_DEF  = 3;
  localparam int unsigned TIMEOUT_W_DEF = 4;

  localparam logic [2:0] OP_LOAD_A   = 3'b000;
  localparam logic [2:0] OP_LOAD_B   = 3'b001;
  localparam logic [2:0] OP_LOAD_IMM = 3'b010;
  localparam logic [2:0] OP_STORE    = 3'b011;
  localparam logic [2:0] OP_JMP      = 3'b100;
  localparam logic [2:0] OP_JMPZ     = 3'b101;
  localparam logic [2:0] OP_RET      = 3'b110;
  localparam logic [2:0] OP_ALU      = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4
  } state_t;

  // Opcodes whose work is a memory transfer rather than a one-cycle execute.
  function automatic logic op_is_mem(input logic [2:0] op);
    return (op == OP_LOAD_A) || (op == OP_LOAD_B) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Request/ready handshake between the control unit and the
// variable-latency instruction/data memory.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter: counts cycles a request is outstanding and flags the
// terminal count (all ones) used as the timeout threshold.
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TIMEOUT_W-1:0] count;

  // Clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + TIMEOUT_W'(1);
  end

  assign tc = (count == '1);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the accumulator processor. Sequences each
// instruction through FETCH/DECODE/EXEC/MEM, handshakes with a
// variable-latency memory and reports memory timeouts.
// Optional feature: define CTRL_JMPZ_EN to make opcode 101 (JMPZ) legal.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W  = OPCODE_W_DEF,
  parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [OPCODE_W-1:0]         opcode,
  input  logic                        sel,
  input  logic                        zero,
  multicycle_control_unit_if.master   mem,
  output logic                        ir_load,
  output logic                        pc_inc,
  output logic                        load_A,
  output logic                        load_B,
  output logic                        wb_A,
  output logic                        wr_mem,
  output logic                        imm,
  output logic                        jmp,
  output logic                        ret,
  output logic                        busy,
  output logic                        illegal,
  output logic                        mem_err
);

  state_t     state, state_next;
  logic [2:0] op;
  logic       op_hi_zero;
  logic       op_legal;
  logic       req;
  logic       we;
  logic       tc;
  logic       timeout;

  assign op         = opcode[2:0];
  assign op_hi_zero = ((opcode >> 3) == '0);

`ifdef CTRL_JMPZ_EN
  assign op_legal = op_hi_zero;
`else
  assign op_legal = op_hi_zero && (op != OP_JMPZ);
  logic unused_zero;
  assign unused_zero = zero;
`endif

  assign timeout = tc && !mem.mem_ready;

  // The counter is held clear whenever no request is outstanding and on the
  // cycle a request ends, so it starts from zero on every FETCH/MEM entry.
  ctrl_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!req || mem.mem_ready || tc),
    .enable (req && !mem.mem_ready),
    .tc     (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and output decode from state, opcode and live inputs.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    we         = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    load_A     = 1'b0;
    load_B     = 1'b0;
    wb_A       = 1'b0;
    wr_mem     = 1'b0;
    imm        = 1'b0;
    jmp        = 1'b0;
    ret        = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout) begin
          mem_err    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (!op_legal) begin
          illegal    = 1'b1;
          state_next = run ? ST_FETCH : ST_IDLE;
        end else if (op_is_mem(op)) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op)
          OP_LOAD_IMM: begin
            imm    = 1'b1;
            load_A = sel;
            load_B = !sel;
          end
          OP_JMP: jmp  = 1'b1;
          OP_RET: ret  = 1'b1;
          OP_ALU: wb_A = 1'b1;
`ifdef CTRL_JMPZ_EN
          OP_JMPZ: jmp = zero;
`endif
          default: ;
        endcase
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_MEM: begin
        req = 1'b1;
        we  = (op == OP_STORE);
        if (mem.mem_ready) begin
          load_A     = (op == OP_LOAD_A);
          load_B     = (op == OP_LOAD_B);
          wr_mem     = (op == OP_STORE);
          state_next = run ? ST_FETCH : ST_IDLE;
        end else if (timeout) begin
          mem_err    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign busy        = (state != ST_IDLE);

endmodule
